// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and
// buffers returned words for decode; redirects flush the buffer and drop stale words.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    input  logic        inst_ready,
    input  logic        pc_src,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_addr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [CW:0]   credit_sum;
    logic          accept;
    logic          take;
    logic          push;
    logic          redirect;
    logic [31:0]   head_word;
    logic [31:0]   head_pc;
    logic [31:0]   head_pc4;
    logic [31:0]   br_off;
    logic [31:0]   target;
    logic          unused_ok;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign credit_sum     = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = credit_sum < CAP;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign inst_valid = count != '0;
    assign head_word  = word_q[rd_ptr];
    assign head_pc    = pc_q[rd_ptr];
    assign head_pc4   = head_pc + 32'd4;

    // Head fields read as zero while empty so nothing stale leaks out.
    assign inst          = inst_valid ? head_word : '0;
    assign inst_pc       = inst_valid ? head_pc : '0;
    assign inst_pc_plus4 = inst_valid ? head_pc4 : '0;

    assign take     = inst_valid & inst_ready;
    assign redirect = take & ((jump == 2'b01) | (jump == 2'b10) | pc_src);
    assign push     = imem_resp_valid & (drop == '0) & ~redirect;
    assign br_off   = {{14{head_word[15]}}, head_word[15:0], 2'b00};

    assign unused_ok = &{1'b0, jr_addr[1:0]};

    always_comb begin
        target = head_pc4 + br_off;
        if (jump == 2'b01)
            target = {head_pc4[31:28], head_word[25:0], 2'b00};
        else if (jump == 2'b10)
            target = {jr_addr[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
            if (redirect) begin
                // Everything still in flight, including this cycle's accept, is stale.
                fetch_pc <= target;
                resp_pc  <= target;
                drop     <= outstanding - CW'(imem_resp_valid) + CW'(accept);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (imem_resp_valid && drop != '0)
                    drop <= drop - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= bump(wr_ptr);
                end
                if (take)
                    rd_ptr <= bump(rd_ptr);
                count <= count + CW'(push) - CW'(take);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr] <= imem_resp_data;
            pc_q[wr_ptr]   <= resp_pc;
        end
    end

endmodule
